// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default widths and the divide-by-zero quotient fill.
package div_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_W      = 6;

    // A divide-by-zero quotient is this bit replicated across the word (all ones).
    localparam logic DIV0_Q_BIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration: shift {A,Q} left, add or subtract
// the divisor depending on the sign of A, and shift in the new quotient bit.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   a_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    input  logic [DATA_WIDTH:0]   m_i,
    output logic [DATA_WIDTH:0]   a_o,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH:0] a_sh;

    // A stays within [-M, M), so shifting never changes its sign; testing
    // a_i's sign is the same as testing the shifted value.
    assign a_sh = {a_i[DATA_WIDTH-1:0], q_i[DATA_WIDTH-1]};
    assign a_o  = a_i[DATA_WIDTH] ? (a_sh + m_i) : (a_sh - m_i);
    assign q_o  = {q_i[DATA_WIDTH-2:0], ~a_o[DATA_WIDTH]};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed divider: one non-restoring iteration per clock, then a
// sign-fixup cycle. Quotient goes to lo, remainder to hi.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  abort,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH:0]   a_q, a_d, m_q, m_d, step_a;
    logic [DATA_WIDTH-1:0] q_q, q_d, step_q;
    logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sgn_q_q, sgn_q_d, sgn_m_q, sgn_m_d, dbz_q, dbz_d;
    logic [DATA_WIDTH-1:0] dividend_mag, divisor_mag, rem_mag, quo, rem;

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    // Magnitudes are held unsigned, so |-2^(W-1)| = 2^(W-1) fits without overflow.
    assign dividend_mag = dividend[DATA_WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;
    assign rem_mag      = a_q[DATA_WIDTH] ? (a_q[DATA_WIDTH-1:0] + m_q[DATA_WIDTH-1:0])
                                          : a_q[DATA_WIDTH-1:0];
    assign quo          = (sgn_q_q ^ sgn_m_q) ? -q_q : q_q;
    assign rem          = sgn_q_q ? -rem_mag : rem_mag;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        sgn_q_d = sgn_q_q;
        sgn_m_d = sgn_m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sgn_q_d = dividend[DATA_WIDTH-1];
                    sgn_m_d = divisor[DATA_WIDTH-1];
                    a_d     = '0;
                    q_d     = dividend_mag;
                    m_d     = {1'b0, divisor_mag};
                    cnt_d   = '0;
                    if (divisor == '0) begin
                        hi_d    = dividend_mag;
                        lo_d    = {DATA_WIDTH{DIV0_Q_BIT}};
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    a_d   = step_a;
                    q_d   = step_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    lo_d    = quo;
                    hi_d    = rem;
                    dbz_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            sgn_q_q <= 1'b0;
            sgn_m_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            sgn_q_q <= sgn_q_d;
            sgn_m_q <= sgn_m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for signed DIV: one non-restoring iteration per clock, not a full combinational array.
- Sits in the ALU beside the combinational divider; the CPU control unit launches it and stalls on busy.
- Results are bit-identical to the combinational DIV: quotient to LO, remainder to HI, same divide-by-zero result.

Parameters:
- DATA_WIDTH, 32, operand width; hi/lo width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when ready=1.
- dividend  in  DATA_WIDTH  signed Q; sampled on the accept edge only.
- divisor  in  DATA_WIDTH  signed M; sampled on the accept edge only.
- abort  in  1  synchronous cancel of an in-flight division.
- ready  out  1  high in IDLE.
- busy  out  1  high in DIV, FIX and DONE.
- done  out  1  one-cycle pulse; hi/lo valid.
- div_by_zero  out  1  qualifies done; registered with the result.
- hi  out  DATA_WIDTH  remainder register.
- lo  out  DATA_WIDTH  quotient register.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - ready=1 after release; busy=0, done=0, div_by_zero=0.
  - hi=0, lo=0; internal A/Q/M/count cleared.
- States:
  - IDLE: ready=1. If start=1, this is the accept edge E0. Latch sign bits, Q_mag, and M_ext={0,|M|}; set A=0, Q=Q_mag, count=0.
    - divisor≠0: go to DIV.
    - divisor=0: write hi=Q_mag, lo=all-ones, div_by_zero=1; go to DONE.
  - DIV: one iteration per edge:
    - Shift {A,Q} left by 1.
    - If A≥0 (before the add), A=A−M_ext; else A=A+M_ext.
    - Q[0] = (new A ≥ 0).
    - count+1; after the DATA_WIDTH-th iteration go to FIX.
  - FIX, single edge:
    - If A<0, A=A+M_ext.
    - Quotient negated if sign(Q) XOR sign(M).
    - Remainder negated if sign(Q).
    - Write lo=quotient, hi=A[DATA_WIDTH-1:0], div_by_zero=0; go to DONE.
  - DONE: done=1 for exactly one cycle, ready=0; next edge go to IDLE.
- Latency:
  - Normal: done high in the cycle after edge E(DATA_WIDTH+1), i.e. E33 for the default.
  - Divide-by-zero: done high in the cycle after E0.
  - ready returns one edge after done.
  - Throughput: one op per DATA_WIDTH+3 cycles (normal).
- Widths: A is DATA_WIDTH+1 bits signed; Q and M_mag are DATA_WIDTH unsigned.
  - Magnitude of the most negative value is 2^(DATA_WIDTH-1), held unsigned; no overflow trap.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, matches the combinational unit).
- Boundary and simultaneous events:
  - start while busy is ignored; no queuing.
  - abort in DIV or FIX: go to IDLE next edge; hi/lo/div_by_zero unchanged; no done.
  - abort in IDLE or DONE has no effect; the DONE pulse still completes.
  - start and abort together in IDLE: start wins (accept).
  - Operand changes after E0 have no effect.
  - Reset mid-operation: immediate return to reset values; no partial hi/lo write.
  - hi/lo hold their value between completions.
  - Illegal state encoding: recover to IDLE.

Decomposition:
- Shared package/header div_pkg:
  - State encodings IDLE=2'd0, DIV=2'd1, FIX=2'd2, DONE=2'd3.
  - DATA_WIDTH default; divide-by-zero quotient constant (all ones).
- One natural sub-module, div_step: combinational single non-restoring iteration.
  - Inputs {A, Q, M_ext}; outputs {A', Q'}.
  - Instantiated once; the FSM registers its outputs.

Test Plan:
- 7 / 2 -> lo=0x00000003, hi=0x00000001; done high 33 edges after accept; ready 1 edge later.
- −7 / 2 (0xFFFFFFF9, 0x2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 7 / −2 -> lo=0xFFFFFFFD, hi=0x00000001.
- −5 / 0 -> lo=0xFFFFFFFF, hi=0x00000005, div_by_zero=1; done in the cycle after accept.
- 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Also 100 / 7 followed by start pulses during busy -> only the first accepted: lo=14, hi=2.
- Launch 100/7, assert abort at iteration 10 -> IDLE next edge, no done, hi/lo keep the previous 0x00000002/0x0000000E.
- Launch, pull rst_n low at iteration 20 -> hi=lo=0, busy=0 immediately. After release, 9/3 -> lo=3, hi=0.
